// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst sequencer that sits upstream of the valid/ready memory.
// It accepts one command (direction, start address, beat count), then issues one
// memory handshake per beat, with the address wrapping modulo DEPTH. On writes it
// pulls one beat from the write-data stream per memory write. On reads it pushes
// one beat to the read-data stream per memory read.
// Every output is a register, so each output changes only on the transitions that
// set or clear it.
module mem_burst_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic                  wd_valid_i,
  output logic                  wd_ready_o,
  input  logic [WIDTH-1:0]      wd_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_last_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_ISSUE,
    RD_ISSUE,
    RD_HOLD,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0]   LEN_MAX  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   len_sat;
  logic [ADDR_WIDTH-1:0] addr_next;

  // A burst never exceeds the memory size.
  // The next address wraps naturally because DEPTH is a power of two.
  always_comb begin
    len_sat   = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;
    addr_next = addr + ADDR_ONE;
  end

  // Burst sequencer: state, beat counter, address and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      addr           <= '0;
      count          <= '0;
      cmd_ready_o    <= 1'b1;
      wd_ready_o     <= 1'b0;
      rd_valid_o     <= 1'b0;
      rd_data_o      <= '0;
      rd_last_o      <= 1'b0;
      mem_valid_o    <= 1'b0;
      mem_wr_rd_en_o <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            addr        <= cmd_addr_i;
            count       <= len_sat;
            if (len_sat == '0) begin
              state <= DONE;
            end else if (cmd_wr_i) begin
              state      <= WR_DATA;
              wd_ready_o <= 1'b1;
            end else begin
              state          <= RD_ISSUE;
              mem_valid_o    <= 1'b1;
              mem_wr_rd_en_o <= 1'b0;
              mem_addr_o     <= cmd_addr_i;
            end
          end
        end

        WR_DATA: begin
          if (wd_valid_i) begin
            state          <= WR_ISSUE;
            wd_ready_o     <= 1'b0;
            mem_valid_o    <= 1'b1;
            mem_wr_rd_en_o <= 1'b1;
            mem_addr_o     <= addr;
            mem_wdata_o    <= wd_data_i;
          end
        end

        WR_ISSUE: begin
          if (mem_ready_i) begin
            mem_valid_o    <= 1'b0;
            mem_wr_rd_en_o <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            addr           <= addr_next;
            count          <= count - LEN_ONE;
            if (count == LEN_ONE) begin
              state <= DONE;
            end else begin
              state      <= WR_DATA;
              wd_ready_o <= 1'b1;
            end
          end
        end

        RD_ISSUE: begin
          if (mem_ready_i) begin
            state       <= RD_HOLD;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            rd_valid_o  <= 1'b1;
            rd_data_o   <= mem_rdata_i;
            rd_last_o   <= (count == LEN_ONE);
            count       <= count - LEN_ONE;
          end
        end

        RD_HOLD: begin
          if (rd_ready_i) begin
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
            if (rd_last_o) begin
              state <= DONE;
            end else begin
              state          <= RD_ISSUE;
              addr           <= addr_next;
              mem_valid_o    <= 1'b1;
              mem_wr_rd_en_o <= 1'b0;
              mem_addr_o     <= addr_next;
            end
          end
        end

        DONE: begin
          state       <= IDLE;
          done_o      <= 1'b1;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed bench for mem_burst_ctrl.
// The bench provides a small memory with a programmable stall, and a read
// consumer with a programmable stall. A transaction-level model predicts the
// memory handshakes and read beats of each burst. A per-cycle monitor checks
// the DUT against that prediction.
module tb_mem_burst_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmdValid = 1'b0;
  logic             cmdWr = 1'b0;
  logic [AW-1:0]    cmdAddr = '0;
  logic [AW:0]      cmdLen = '0;
  logic             wdValid = 1'b0;
  logic [WIDTH-1:0] wdData = '0;
  logic             rdReady = 1'b0;
  logic             memReady = 1'b0;
  logic [WIDTH-1:0] memRdata;

  logic             cmd_ready_o, wd_ready_o, rd_valid_o, rd_last_o;
  logic             mem_valid_o, mem_wr_rd_en_o, busy_o, done_o;
  logic [WIDTH-1:0] rd_data_o, mem_wdata_o;
  logic [AW-1:0]    mem_addr_o;

  mem_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmdValid), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmdWr),
    .cmd_addr_i(cmdAddr), .cmd_len_i(cmdLen),
    .wd_valid_i(wdValid), .wd_ready_o(wd_ready_o), .wd_data_i(wdData),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rdReady), .rd_data_o(rd_data_o),
    .rd_last_o(rd_last_o),
    .mem_valid_o(mem_valid_o), .mem_wr_rd_en_o(mem_wr_rd_en_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(memReady), .mem_rdata_i(memRdata),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]    addr;
    logic             wr;
    logic [WIDTH-1:0] data;
  } memTxn_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } rdBeat_t;

  memTxn_t          expMemQ[$];
  rdBeat_t          expRdQ[$];
  logic [WIDTH-1:0] wdQ[$];
  logic [WIDTH-1:0] memArr [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int memStall = 0, memWait = 0;
  int rdStallBeat = -1, rdStallCycles = 0, rdWait = 0, rdBeatIdx = 0;
  int memFires = 0, doneCount = 0, doneCycle = 0, acceptCycle = 0;
  bit wdFire = 1'b0;
  int               memAddrLog[$];
  logic [WIDTH-1:0] rdLog[$];
  bit               rdLastLog[$];

  bit               memPendPrev = 1'b0, rdPendPrev = 1'b0;
  logic             prevWr, prevRdLast;
  logic [AW-1:0]    prevAddr;
  logic [WIDTH-1:0] prevWdata, prevRdData;

  assign memRdata = memArr[mem_addr_o];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready_o), 64'd1);
    checkOutput({tag, "_ctrl"}, 64'({wd_ready_o, rd_valid_o, rd_last_o, mem_valid_o,
                                      mem_wr_rd_en_o, busy_o, done_o}), 64'd0);
    checkOutput({tag, "_buses"}, 64'({rd_data_o, mem_addr_o, mem_wdata_o}), 64'd0);
  endtask

  // Transaction-level model: the burst is cut to DEPTH beats (and to maxBeats when a reset
  // will abandon the rest). Addresses run modulo DEPTH. Reads return the data the model last wrote.
  task automatic modelBurst(input bit wr, input int addr, input int len, input int base,
                            input int maxBeats);
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    if (maxBeats < n) n = maxBeats;
    for (int i = 0; i < n; i++) begin
      int      a;
      memTxn_t t;
      rdBeat_t b;
      a      = (addr + i) % DEPTH;
      t.addr = a[AW-1:0];
      t.wr   = wr;
      t.data = wr ? WIDTH'(base + i) : '0;
      expMemQ.push_back(t);
      if (wr) begin
        shadow[a] = WIDTH'(base + i);
      end else begin
        b.data = shadow[a];
        b.last = (i == n - 1);
        expRdQ.push_back(b);
      end
    end
  endtask

  task automatic applyStimulus(input bit wr, input int addr, input int len, input int base,
                               input int maxBeats);
    bit ok;
    int n;
    ok = 1'b0;
    modelBurst(wr, addr, len, base, maxBeats);
    n = (len > DEPTH) ? DEPTH : len;
    if (wr) for (int i = 0; i < n; i++) wdQ.push_back(WIDTH'(base + i));
    rdBeatIdx = 0;
    rdWait    = 0;
    memFires  = 0;
    memAddrLog.delete();
    rdLog.delete();
    rdLastLog.delete();
    @(posedge clk); #3;
    cmdValid = 1'b1;
    cmdWr    = wr;
    cmdAddr  = AW'(addr);
    cmdLen   = (AW+1)'(len);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("cmd_accept", 64'(ok), 64'd1);
    @(posedge clk); #3;
    cmdValid = 1'b0;
  endtask

  task automatic waitDone(input int target, input int maxCycles);
    int k;
    k = 0;
    while (doneCount < target && k < maxCycles) begin
      @(negedge clk);
      k++;
    end
    checkOutput("done_wait", 64'(doneCount >= target), 64'd1);
  endtask

  // Bench-side environment: write-data source, memory ready with stall, read consumer with stall.
  always @(posedge clk) begin
    cycle++;
    if (wdFire && wdQ.size() > 0) wdQ.delete(0);
    #2;
    if (wdQ.size() > 0) begin
      wdValid = 1'b1;
      wdData  = wdQ[0];
    end else begin
      wdValid = 1'b0;
      wdData  = '0;
    end
    if (rst || !mem_valid_o) begin
      memReady = 1'b0;
      memWait  = 0;
    end else if (memWait >= memStall) begin
      memReady = 1'b1;
    end else begin
      memReady = 1'b0;
      memWait++;
    end
    if (rst || !rd_valid_o) begin
      rdReady = 1'b0;
    end else if (rdBeatIdx == rdStallBeat && rdWait < rdStallCycles) begin
      rdReady = 1'b0;
      rdWait++;
    end else begin
      rdReady = 1'b1;
    end
  end

  // Monitor: per-cycle protocol rules plus scoreboard comparison of every handshake.
  always @(negedge clk) begin
    memTxn_t t;
    rdBeat_t b;
    if (rst) begin
      wdFire      = 1'b0;
      memPendPrev = 1'b0;
      rdPendPrev  = 1'b0;
    end else begin
      if (!mem_valid_o)
        checkOutput("idle_bus", 64'({mem_wr_rd_en_o, mem_addr_o, mem_wdata_o}), 64'd0);
      if (rd_valid_o)
        checkOutput("rd_hold_no_req", 64'(mem_valid_o), 64'd0);
      if (memPendPrev)
        checkOutput("mem_hold", 64'({mem_valid_o, mem_wr_rd_en_o, mem_addr_o, mem_wdata_o}),
                    64'({1'b1, prevWr, prevAddr, prevWdata}));
      if (rdPendPrev)
        checkOutput("rd_hold", 64'({rd_valid_o, rd_last_o, rd_data_o}),
                    64'({1'b1, prevRdLast, prevRdData}));
      if (mem_valid_o && memReady) begin
        memFires++;
        memAddrLog.push_back(int'(mem_addr_o));
        checkOutput("mem_expected", 64'(expMemQ.size() != 0), 64'd1);
        if (expMemQ.size() != 0) begin
          t = expMemQ.pop_front();
          checkOutput("mem_addr", 64'(mem_addr_o), 64'(t.addr));
          checkOutput("mem_dir", 64'(mem_wr_rd_en_o), 64'(t.wr));
          if (t.wr) checkOutput("mem_wdata", 64'(mem_wdata_o), 64'(t.data));
        end
        if (mem_wr_rd_en_o) memArr[mem_addr_o] = mem_wdata_o;
      end
      if (rd_valid_o && rdReady) begin
        rdBeatIdx++;
        rdLog.push_back(rd_data_o);
        rdLastLog.push_back(rd_last_o);
        checkOutput("rd_expected", 64'(expRdQ.size() != 0), 64'd1);
        if (expRdQ.size() != 0) begin
          b = expRdQ.pop_front();
          checkOutput("rd_data", 64'(rd_data_o), 64'(b.data));
          checkOutput("rd_last", 64'(rd_last_o), 64'(b.last));
        end
      end
      wdFire = wdValid && wd_ready_o;
      if (done_o) begin
        doneCount++;
        doneCycle = cycle;
      end
      if (cmdValid && cmd_ready_o) acceptCycle = cycle;
      memPendPrev = mem_valid_o && !memReady;
      prevWr      = mem_wr_rd_en_o;
      prevAddr    = mem_addr_o;
      prevWdata   = mem_wdata_o;
      rdPendPrev  = rd_valid_o && !rdReady;
      prevRdLast  = rd_last_o;
      prevRdData  = rd_data_o;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time 500000 reached, required completion before it");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int expAddr [4];
    int k;
    expAddr = '{14, 15, 0, 1};
    for (int i = 0; i < DEPTH; i++) begin
      memArr[i] = '0;
      shadow[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #3;
    rst = 1'b0;

    // Full-depth write then read back.
    applyStimulus(1'b1, 0, 16, 'h1000, 16);
    waitDone(1, 200);
    applyStimulus(1'b0, 0, 16, 0, 16);
    waitDone(2, 200);
    checkOutput("t1_beats", 64'(rdLog.size()), 64'd16);
    checkOutput("t1_first", 64'(rdLog[0]), 64'h1000);
    checkOutput("t1_last_data", 64'(rdLog[15]), 64'h100F);
    checkOutput("t1_last_flag", 64'({rdLastLog[14], rdLastLog[15]}), 64'b01);
    checkOutput("t1_done", 64'(doneCount), 64'd2);

    // Wrapping burst from address 14.
    applyStimulus(1'b1, 14, 4, 'h2000, 16);
    waitDone(3, 100);
    for (int i = 0; i < 4; i++) checkOutput("t2_wr_addr", 64'(memAddrLog[i]), 64'(expAddr[i]));
    applyStimulus(1'b0, 14, 4, 0, 16);
    waitDone(4, 100);
    checkOutput("t2_rd0", 64'(rdLog[0]), 64'h2000);
    checkOutput("t2_rd3", 64'(rdLog[3]), 64'h2003);

    // Zero-length commands: no memory traffic, done two cycles after accept.
    applyStimulus(1'b1, 5, 0, 0, 16);
    waitDone(5, 20);
    checkOutput("len0_wr_mem", 64'(memFires), 64'd0);
    checkOutput("len0_done_lat", 64'(doneCycle - acceptCycle), 64'd2);
    applyStimulus(1'b0, 5, 0, 0, 16);
    waitDone(6, 20);
    checkOutput("len0_rd_mem", 64'(memFires), 64'd0);

    // Oversized length saturates to DEPTH beats.
    applyStimulus(1'b1, 3, 20, 'h3000, 16);
    waitDone(7, 200);
    checkOutput("len20_beats", 64'(memFires), 64'd16);
    checkOutput("len20_wrap_addr", 64'(memAddrLog[15]), 64'd2);

    // Memory stalls 5 cycles per beat.
    memStall = 5;
    applyStimulus(1'b1, 8, 3, 'h4000, 16);
    waitDone(8, 200);
    applyStimulus(1'b0, 8, 3, 0, 16);
    waitDone(9, 200);
    memStall = 0;
    checkOutput("stall_rd2", 64'(rdLog[2]), 64'h4002);

    // Consumer holds off the third read beat for 3 cycles.
    rdStallBeat   = 2;
    rdStallCycles = 3;
    applyStimulus(1'b0, 0, 4, 0, 16);
    waitDone(10, 100);
    rdStallBeat = -1;
    checkOutput("rdstall_rd2", 64'(rdLog[2]), 64'h300F);
    checkOutput("rdstall_rd3", 64'(rdLog[3]), 64'h3000);

    // Reset after the third write beat of an 8-beat burst.
    applyStimulus(1'b1, 4, 8, 'hA0, 3);
    k = 0;
    while (memFires < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("reset_reach_beat3", 64'(memFires), 64'd3);
    @(posedge clk); #3;
    rst = 1'b1;
    wdQ.delete();
    @(negedge clk);
    checkResetOutputs("midreset");
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("midreset_no_done", 64'(doneCount), 64'd10);
    checkOutput("midreset_beats", 64'(memFires), 64'd3);
    checkOutput("midreset_exp_empty", 64'(expMemQ.size()), 64'd0);
    applyStimulus(1'b0, 4, 4, 0, 16);
    waitDone(11, 100);
    checkOutput("midreset_rd0", 64'(rdLog[0]), 64'h00A0);
    checkOutput("midreset_rd2", 64'(rdLog[2]), 64'h00A2);
    checkOutput("midreset_rd3", 64'(rdLog[3]), 64'h3004);

    checkOutput("end_mem_q", 64'(expMemQ.size()), 64'd0);
    checkOutput("end_rd_q", 64'(expRdQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
